// File: rtl/l1i_miss_handler.sv
// rtl/l1i_miss_handler.sv - L1I miss handler: fetches the missed line and its successor, then updates the cache
module l1i_miss_handler #(
  parameter int fetchingAddressWidth    = 64,
  parameter int cacheLineWidth          = 512,
  parameter int offsetWidth             = 6,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0]    missedAddress_i,
  input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
  input  logic [PidSize-1:0]                 missedPid_i,
  input  logic [TidSize-1:0]                 missedTid_i,
  output logic                               busy_o,
  output logic                               droppedMiss_o,
  output logic                               memReq_o,
  output logic [fetchingAddressWidth-1:0]    memReqAddress_o,
  input  logic                               memReqReady_i,
  input  logic                               memRespValid_i,
  input  logic [0:cacheLineWidth-1]          memRespData_i,
  output logic                               cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o,
  output logic [0:cacheLineWidth-1]          cacheUpdateLine1_o,
  output logic [0:cacheLineWidth-1]          cacheUpdateLine2_o,
  output logic [PidSize-1:0]                 cacheUpdatePid_o,
  output logic [TidSize-1:0]                 cacheUpdateTid_o,
  output logic [instructionCounterWidth-1:0] cacheUpdateInstMajorId_o
);
  localparam int AW = fetchingAddressWidth;
  localparam logic [AW-1:0] LineStride = AW'(1) << offsetWidth;

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, UPDATE} state_t;

  state_t                               state_q, state_d;
  logic                                 capture_d;
  logic                                 dropped_q, dropped_d;
  logic [AW-1:0]                        addr_q, base_q;
  logic [PidSize-1:0]                   pid_q;
  logic [TidSize-1:0]                   tid_q;
  logic [instructionCounterWidth-1:0]   id_q;
  logic [0:cacheLineWidth-1]            line1_q;
  logic [AW-1:0]                        upd_addr_q;
  logic [0:cacheLineWidth-1]            upd_line1_q, upd_line2_q;
  logic [PidSize-1:0]                   upd_pid_q;
  logic [TidSize-1:0]                   upd_tid_q;
  logic [instructionCounterWidth-1:0]   upd_id_q;
  logic                                 same_line;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture_d = 1'b0;
    case (state_q)
      IDLE:   if (cacheMiss_i) begin
                state_d   = REQ1;
                capture_d = 1'b1;
              end
      REQ1:   if (memReqReady_i)  state_d = WAIT1;
      WAIT1:  if (memRespValid_i) state_d = REQ2;
      REQ2:   if (memReqReady_i)  state_d = WAIT2;
      WAIT2:  if (memRespValid_i) state_d = UPDATE;
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A miss to the line already in flight (same owner) is absorbed; anything else is rejected.
  assign same_line = (missedAddress_i[AW-1:offsetWidth] == base_q[AW-1:offsetWidth]) &&
                     (missedPid_i == pid_q);
  assign dropped_d = busy_o && cacheMiss_i && !same_line;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dropped_q   <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      pid_q       <= '0;
      tid_q       <= '0;
      id_q        <= '0;
      line1_q     <= '0;
      upd_addr_q  <= '0;
      upd_line1_q <= '0;
      upd_line2_q <= '0;
      upd_pid_q   <= '0;
      upd_tid_q   <= '0;
      upd_id_q    <= '0;
    end else begin
      dropped_q <= dropped_d;
      if (capture_d) begin
        addr_q <= missedAddress_i;
        base_q <= {missedAddress_i[AW-1:offsetWidth], {offsetWidth{1'b0}}};
        pid_q  <= missedPid_i;
        tid_q  <= missedTid_i;
        id_q   <= missedInstMajorId_i;
      end
      if (state_q == WAIT1 && memRespValid_i) line1_q <= memRespData_i;
      // Update fields load only on entry to UPDATE so they hold between strobes.
      if (state_q == WAIT2 && memRespValid_i) begin
        upd_addr_q  <= addr_q;
        upd_line1_q <= line1_q;
        upd_line2_q <= memRespData_i;
        upd_pid_q   <= pid_q;
        upd_tid_q   <= tid_q;
        upd_id_q    <= id_q;
      end
    end
  end

  assign busy_o                   = (state_q != IDLE);
  assign memReq_o                 = (state_q == REQ1) || (state_q == REQ2);
  assign memReqAddress_o          = (state_q == REQ2) ? base_q + LineStride : base_q;
  assign droppedMiss_o            = dropped_q;
  assign cacheUpdate_o            = (state_q == UPDATE);
  assign cacheUpdateAddress_o     = upd_addr_q;
  assign cacheUpdateLine1_o       = upd_line1_q;
  assign cacheUpdateLine2_o       = upd_line2_q;
  assign cacheUpdatePid_o         = upd_pid_q;
  assign cacheUpdateTid_o         = upd_tid_q;
  assign cacheUpdateInstMajorId_o = upd_id_q;
endmodule

// File: tb/tb_l1i_miss_handler.sv
// tb/tb_l1i_miss_handler.sv - directed scoreboard bench for l1i_miss_handler
module tb_l1i_miss_handler;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss_i;
  logic [63:0]  addr_i;
  logic [63:0]  id_i;
  logic [19:0]  pid_i;
  logic [15:0]  tid_i;
  logic         busy, dropped, mem_req, ready, resp_valid, upd;
  logic [63:0]  mem_addr, upd_addr, upd_id;
  logic [0:511] resp_data, upd_l1, upd_l2;
  logic [19:0]  upd_pid;
  logic [15:0]  upd_tid;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] l1;
    logic [511:0] l2;
    logic [19:0]  pid;
    logic [15:0]  tid;
    logic [63:0]  id;
  } upd_t;

  logic [63:0]  req_q[$];
  upd_t         upd_q[$];
  logic [511:0] last_l1;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  l1i_miss_handler dut (
    .clock_i(clk), .reset_i(rst), .cacheMiss_i(miss_i), .missedAddress_i(addr_i),
    .missedInstMajorId_i(id_i), .missedPid_i(pid_i), .missedTid_i(tid_i),
    .busy_o(busy), .droppedMiss_o(dropped), .memReq_o(mem_req), .memReqAddress_o(mem_addr),
    .memReqReady_i(ready), .memRespValid_i(resp_valid), .memRespData_i(resp_data),
    .cacheUpdate_o(upd), .cacheUpdateAddress_o(upd_addr), .cacheUpdateLine1_o(upd_l1),
    .cacheUpdateLine2_o(upd_l2), .cacheUpdatePid_o(upd_pid), .cacheUpdateTid_o(upd_tid),
    .cacheUpdateInstMajorId_o(upd_id)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 plain, 1 merge+drop in WAIT1, 2 spurious response in REQ2, 3 reset in WAIT2
  task automatic service(input logic [63:0] addr, input logic [19:0] pid, input logic [15:0] tid,
                         input logic [63:0] id, input logic [511:0] la, input logic [511:0] lb,
                         input int rdy_delay, input int mode);
    upd_t        e;
    logic [63:0] base, exp_addr;
    base = {addr[63:6], 6'd0};
    req_q.push_back(base);
    req_q.push_back(base + 64'h40);
    e.addr = addr; e.l1 = la; e.l2 = lb; e.pid = pid; e.tid = tid; e.id = id;
    upd_q.push_back(e);
    miss_i = 1'b1; addr_i = addr; pid_i = pid; tid_i = tid; id_i = id;
    step();
    miss_i = 1'b0;
    exp_addr = req_q.pop_front();
    chk("req1_busy", busy, 1);
    chk("req1_valid", mem_req, 1);
    chk("req1_addr", mem_addr, exp_addr);
    for (int i = 0; i < rdy_delay; i++) begin
      ready = 1'b0;
      step();
      chk("req1_hold_valid", mem_req, 1);
      chk("req1_hold_addr", mem_addr, exp_addr);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wait1_noreq", mem_req, 0);
    if (mode == 1) begin
      miss_i = 1'b1; addr_i = base + 64'h8; pid_i = pid;
      step();
      chk("merge_nodrop", dropped, 0);
      addr_i = base + 64'h100;
      step();
      miss_i = 1'b0;
      chk("drop_pulse", dropped, 1);
      step();
      chk("drop_end", dropped, 0);
      chk("drop_still_busy", busy, 1);
    end
    resp_valid = 1'b1; resp_data = la;
    step();
    resp_valid = 1'b0; resp_data = '0;
    exp_addr = req_q.pop_front();
    chk("req2_valid", mem_req, 1);
    chk("req2_addr", mem_addr, exp_addr);
    if (mode == 2) begin
      resp_valid = 1'b1; resp_data = ~la;
      step();
      resp_valid = 1'b0; resp_data = '0;
      chk("req2_spurious_valid", mem_req, 1);
      chk("req2_spurious_addr", mem_addr, exp_addr);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wait2_noupd", upd, 0);
    chk("wait2_noreq", mem_req, 0);
    if (mode == 3) begin
      rst = 1'b1;
      #1;
      e = upd_q.pop_front();
      chk("rst_busy", busy, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_req_addr", mem_addr, 0);
      chk("rst_upd", upd, 0);
      chk("rst_upd_addr", upd_addr, 0);
      chk("rst_upd_l1", upd_l1, 0);
      chk("rst_upd_pid", upd_pid, 0);
      return;
    end
    resp_valid = 1'b1; resp_data = lb;
    step();
    resp_valid = 1'b0; resp_data = '0;
    e = upd_q.pop_front();
    chk("upd_strobe", upd, 1);
    chk("upd_addr", upd_addr, e.addr);
    chk("upd_l1", upd_l1, e.l1);
    chk("upd_l2", upd_l2, e.l2);
    chk("upd_pid", upd_pid, e.pid);
    chk("upd_tid", upd_tid, e.tid);
    chk("upd_id", upd_id, e.id);
    step();
    chk("upd_oneshot", upd, 0);
    chk("idle_busy", busy, 0);
    chk("upd_hold_l1", upd_l1, e.l1);
    chk("upd_hold_addr", upd_addr, e.addr);
    last_l1 = e.l1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; miss_i = 1'b0; addr_i = '0; id_i = '0; pid_i = '0; tid_i = '0;
    ready = 1'b0; resp_valid = 1'b0; resp_data = '0; last_l1 = '0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_req", mem_req, 0);
    chk("reset_upd", upd, 0);
    chk("reset_dropped", dropped, 0);
    chk("reset_l2", upd_l2, 0);
    rst = 1'b0;
    step();

    resp_valid = 1'b1; resp_data = {16{32'hDEAD_BEEF}};
    step();
    resp_valid = 1'b0;
    chk("idle_spurious_busy", busy, 0);
    chk("idle_spurious_l1", upd_l1, 0);

    service(64'h4, 20'd5, 16'd3, 64'h1234, {16{32'hAAAA_0001}}, {16{32'hBBBB_0002}}, 0, 0);
    service(64'h2C0, 20'd7, 16'd1, 64'h99, {16{32'h1111_2222}}, {16{32'h3333_4444}}, 3, 0);
    service(64'hFFFF_FFFF_FFFF_FFC8, 20'hFFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            {8{64'h0123_4567_89AB_CDEF}}, {8{64'hFEDC_BA98_7654_3210}}, 0, 0);
    service(64'h4, 20'd5, 16'd3, 64'h55, {16{32'hC0C0_0003}}, {16{32'hD0D0_0004}}, 0, 1);

    resp_valid = 1'b1; resp_data = {16{32'hBAD0_BAD0}};
    step();
    resp_valid = 1'b0;
    chk("idle_spurious2_busy", busy, 0);
    chk("idle_spurious2_l1", upd_l1, last_l1);

    service(64'h1000, 20'd9, 16'd2, 64'h77, {16{32'hE0E0_0005}}, {16{32'hF0F0_0006}}, 1, 2);
    service(64'h3000, 20'd4, 16'd8, 64'h88, {16{32'h0A0A_0007}}, {16{32'h0B0B_0008}}, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    resp_valid = 1'b1; resp_data = {16{32'h0B0B_0008}};
    step();
    resp_valid = 1'b0; resp_data = '0;
    chk("late_resp_busy", busy, 0);
    chk("late_resp_upd", upd, 0);
    chk("late_resp_l2", upd_l2, 0);
    service(64'h3000, 20'd4, 16'd8, 64'h89, {16{32'h0C0C_0009}}, {16{32'h0D0D_000A}}, 0, 0);

    chk("req_queue_empty", 512'(req_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
